odometer_scan_ctrl: RTL and testbench

- Sequencer and evaluator that sits directly downstream of sn_cdir_decoder and also drives that decoder's control inputs.
- Steps through every CDIR sensor pair, running a reset→measure cycle on each, and captures r_freq/s_freq on valid_out.
- Computes the per-pair aging delta (reference count minus stressed count) and accumulates it.
- Reports sum, average, worst pair and an "aged/recycled" verdict against a programmable threshold.

---
 rtl/odometer_scan_ctrl.sv | 174 +++++++++++++++++
 tb/tb_odometer_scan_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/odometer_scan_ctrl.sv
// Scan sequencer for the CDIR sensor pairs: drives the decoder through reset/measure
// per pair, accumulates saturating aging deltas and reports sum/avg/worst/verdict.
module odometer_scan_ctrl #(
    parameter int NO_CDIR      = 8,
    parameter int MUX_SEL_SIZE = 3,
    parameter int RESET_CYCLES = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [31:0]               threshold,
    output logic [1:0]                mode,
    output logic [MUX_SEL_SIZE-1:0]   r_mux_sel,
    output logic [MUX_SEL_SIZE-1:0]   s_mux_sel,
    input  logic [31:0]               r_freq,
    input  logic [31:0]               s_freq,
    input  logic                      valid_out,
    output logic                      busy,
    output logic                      done,
    output logic [32+MUX_SEL_SIZE-1:0] diff_sum,
    output logic [31:0]               avg_diff,
    output logic [31:0]               max_diff,
    output logic [MUX_SEL_SIZE-1:0]   max_idx,
    output logic                      aged,
    output logic                      timeout_err
);

    localparam int CMAX = (TIMEOUT > RESET_CYCLES) ? TIMEOUT : RESET_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int SW   = 32 + MUX_SEL_SIZE;

    typedef enum logic [2:0] {S_IDLE, S_INIT, S_MEAS, S_CAPT, S_NEXT, S_FIN} state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [MUX_SEL_SIZE-1:0] idx_q, idx_d;
    logic [31:0]             thr_q, thr_d;
    logic [31:0]             rcap_q, rcap_d, scap_q, scap_d;
    logic [SW-1:0]           sum_q, sum_d;
    logic [31:0]             avg_q, avg_d, max_q, max_d;
    logic [MUX_SEL_SIZE-1:0] maxi_q, maxi_d;
    logic                    aged_q, aged_d, tout_q, tout_d;
    logic [1:0]              mode_q, mode_d;
    logic                    busy_q, busy_d, done_q, done_d;
    logic [31:0]             delta;

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        idx_d   = idx_q;
        thr_d   = thr_q;
        rcap_d  = rcap_q;
        scap_d  = scap_q;
        sum_d   = sum_q;
        avg_d   = avg_q;
        max_d   = max_q;
        maxi_d  = maxi_q;
        aged_d  = aged_q;
        tout_d  = tout_q;
        delta   = (rcap_q >= scap_q) ? (rcap_q - scap_q) : '0;

        unique case (state_q)
            S_IDLE: if (start) begin
                thr_d   = threshold;
                idx_d   = '0;
                sum_d   = '0;
                max_d   = '0;
                maxi_d  = '0;
                tout_d  = 1'b0;
                state_d = S_INIT;
            end
            S_INIT: begin
                if (cnt_q == CW'(RESET_CYCLES - 1)) state_d = S_MEAS;
                else                                cnt_d   = cnt_q + 1'b1;
            end
            S_MEAS: begin
                // cnt_q == 0 marks the pipeline-flush cycle where valid_out is stale
                if (cnt_q != '0 && valid_out) begin
                    rcap_d  = r_freq;
                    scap_d  = s_freq;
                    state_d = S_CAPT;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    tout_d  = 1'b1;
                    rcap_d  = '0;
                    scap_d  = '0;
                    state_d = S_CAPT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_CAPT: begin
                sum_d = sum_q + SW'(delta);
                if (delta > max_q) begin
                    max_d  = delta;
                    maxi_d = idx_q;
                end
                state_d = S_NEXT;
            end
            S_NEXT: begin
                if (idx_q == MUX_SEL_SIZE'(NO_CDIR - 1)) begin
                    // Loaded on FIN entry so the results are already valid alongside done
                    avg_d   = sum_q[SW-1:MUX_SEL_SIZE];
                    aged_d  = (sum_q[SW-1:MUX_SEL_SIZE] >= thr_q);
                    state_d = S_FIN;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_INIT;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        unique case (state_d)
            S_INIT:          mode_d = 2'b00;
            S_MEAS:          mode_d = 2'b10;
            S_CAPT, S_NEXT:  mode_d = 2'b11;
            default:         mode_d = 2'b01;
        endcase
        busy_d = (state_d == S_INIT) || (state_d == S_MEAS) ||
                 (state_d == S_CAPT) || (state_d == S_NEXT);
        done_d = (state_d == S_FIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            thr_q   <= '0;
            rcap_q  <= '0;
            scap_q  <= '0;
            sum_q   <= '0;
            avg_q   <= '0;
            max_q   <= '0;
            maxi_q  <= '0;
            aged_q  <= 1'b0;
            tout_q  <= 1'b0;
            mode_q  <= 2'b00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            thr_q   <= thr_d;
            rcap_q  <= rcap_d;
            scap_q  <= scap_d;
            sum_q   <= sum_d;
            avg_q   <= avg_d;
            max_q   <= max_d;
            maxi_q  <= maxi_d;
            aged_q  <= aged_d;
            tout_q  <= tout_d;
            mode_q  <= mode_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign mode        = mode_q;
    assign r_mux_sel   = idx_q;
    assign s_mux_sel   = idx_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign diff_sum    = sum_q;
    assign avg_diff    = avg_q;
    assign max_diff    = max_q;
    assign max_idx     = maxi_q;
    assign aged        = aged_q;
    assign timeout_err = tout_q;

endmodule

// File: tb/tb_odometer_scan_ctrl.sv
// Bench for odometer_scan_ctrl: behavioural decoder plus a per-scan reference model
// computed from the pair values, directed test-plan scans and randomized scans.
module tb_odometer_scan_ctrl;

    localparam int N  = 8;
    localparam int M  = 3;
    localparam int RC = 4;
    localparam int TO = 255;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [31:0]   threshold = '0;
    logic [1:0]    mode;
    logic [M-1:0]  r_mux_sel, s_mux_sel;
    logic [31:0]   r_freq, s_freq;
    logic          valid_out = 1'b0;
    logic          busy, done;
    logic [32+M-1:0] diff_sum;
    logic [31:0]   avg_diff, max_diff;
    logic [M-1:0]  max_idx;
    logic          aged, timeout_err;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    logic [31:0] rf [N];
    logic [31:0] sf [N];
    int          dly [N];
    bit          nv [N];
    int          mcnt = 0;

    odometer_scan_ctrl #(.NO_CDIR(N), .MUX_SEL_SIZE(M), .RESET_CYCLES(RC), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .threshold(threshold),
        .mode(mode), .r_mux_sel(r_mux_sel), .s_mux_sel(s_mux_sel),
        .r_freq(r_freq), .s_freq(s_freq), .valid_out(valid_out),
        .busy(busy), .done(done), .diff_sum(diff_sum), .avg_diff(avg_diff),
        .max_diff(max_diff), .max_idx(max_idx), .aged(aged), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    assign r_freq = rf[r_mux_sel];
    assign s_freq = sf[s_mux_sel];

    // Decoder model: valid_out rises dly cycles after the first mode=10 cycle
    always @(negedge clk) begin
        if (mode == 2'b10) begin
            mcnt      <= mcnt + 1;
            valid_out <= !nv[r_mux_sel] && (mcnt + 1 >= dly[r_mux_sel] + 1);
        end else begin
            mcnt      <= 0;
            valid_out <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_plan(input int s5_lo, input int s2_hi, input bit nv3);
        for (int i = 0; i < N; i++) begin
            rf[i] = 32'h1000; sf[i] = 32'h0F00; dly[i] = 100; nv[i] = 1'b0;
        end
        if (s5_lo != 0) sf[5] = 32'h0E00;
        if (s2_hi != 0) sf[2] = 32'h1100;
        nv[3] = nv3;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_mode"}, 64'(mode), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_sel"}, 64'({r_mux_sel, s_mux_sel}), 64'd0);
        check({tag, "_sum"}, 64'(diff_sum), 64'd0);
        check({tag, "_avg"}, 64'(avg_diff), 64'd0);
        check({tag, "_max"}, 64'({max_diff, max_idx}), 64'd0);
        check({tag, "_flags"}, 64'({aged, timeout_err}), 64'd0);
    endtask

    // Runs one full scan from IDLE and compares against the reference model.
    // poke: also pulse start mid-scan and in the done cycle (both must be ignored).
    task automatic run_scan(input string tag, input logic [31:0] thr, input bit poke);
        longint unsigned e_sum = 0, d;
        longint unsigned e_max = 0;
        int e_idx = 0, e_lat = 1, e_m10 = 0, len, c, n00, n10, n11;
        bit e_to = 0;
        logic [31:0] e_avg;
        for (int i = 0; i < N; i++) begin
            if (nv[i]) begin
                d = 0; len = TO; e_to = 1;
            end else begin
                d   = (rf[i] >= sf[i]) ? longint'(rf[i]) - longint'(sf[i]) : 0;
                len = (dly[i] < 1) ? 2 : dly[i] + 1;
            end
            e_sum += d;
            if (d > e_max) begin e_max = d; e_idx = i; end
            e_lat += RC + len + 2;
            e_m10 += len;
        end
        e_avg = 32'(e_sum / N);

        @(negedge clk);
        start = 1'b1; threshold = thr;
        @(negedge clk);
        start = 1'b0; threshold = $urandom;
        c = 1; n00 = 0; n10 = 0; n11 = 0;
        check({tag, "_busy_rise"}, 64'(busy), 64'd1);
        while (!done && c < 20000) begin
            if (mode == 2'b00) n00++;
            else if (mode == 2'b10) n10++;
            else if (mode == 2'b11) n11++;
            if (poke) start = (c == 60);
            @(negedge clk);
            c++;
        end
        start = 1'b0;
        if (!done) begin
            check({tag, "_done_seen"}, 64'd0, 64'd1);
            return;
        end
        check({tag, "_latency"}, 64'(c), 64'(e_lat));
        check({tag, "_n00"}, 64'(n00), 64'(N * RC));
        check({tag, "_n10"}, 64'(n10), 64'(e_m10));
        check({tag, "_n11"}, 64'(n11), 64'(N * 2));
        check({tag, "_fin_mode_busy"}, 64'({mode, busy}), 64'({2'b01, 1'b0}));
        check({tag, "_diff_sum"}, 64'(diff_sum), e_sum);
        check({tag, "_avg_diff"}, 64'(avg_diff), 64'(e_avg));
        check({tag, "_max_diff"}, 64'(max_diff), e_max);
        check({tag, "_max_idx"}, 64'(max_idx), 64'(e_idx));
        check({tag, "_aged"}, 64'(aged), 64'(e_avg >= thr));
        check({tag, "_timeout_err"}, 64'(timeout_err), 64'(e_to));
        if (poke) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
        check({tag, "_idle_busy"}, 64'(busy), 64'd0);
        check({tag, "_avg_hold"}, 64'(avg_diff), 64'(e_avg));
    endtask

    initial begin
        int c;
        set_plan(0, 0, 0);
        #1;
        check_reset_vals("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_mode", 64'(mode), 64'd1);

        set_plan(0, 0, 0); run_scan("plan_base", 32'h80, 1'b0);
        set_plan(1, 0, 0); run_scan("plan_pair5", 32'h80, 1'b0);
        set_plan(0, 1, 0); run_scan("plan_pair2_sat", 32'h80, 1'b0);
        set_plan(0, 0, 1); run_scan("plan_pair3_tout", 32'h80, 1'b0);
        set_plan(0, 0, 0); dly[1] = 0; run_scan("plan_busy_start_thr0", 32'h0, 1'b1);

        // Asynchronous reset while pair 4 is measuring
        set_plan(1, 0, 0);
        @(negedge clk);
        start = 1'b1; threshold = 32'h80;
        @(negedge clk);
        start = 1'b0;
        c = 0;
        while (!(r_mux_sel == 3'd4 && mode == 2'b10) && c < 5000) begin
            @(negedge clk); c++;
        end
        check("rst_reach_pair4", 64'(c < 5000), 64'd1);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_scan("after_reset", 32'h80, 1'b0);

        for (int s = 0; s < 6; s++) begin
            logic [31:0] thr;
            longint unsigned tot = 0;
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 1) == 0) begin
                    rf[i] = $urandom; sf[i] = $urandom;
                end else begin
                    rf[i] = $urandom_range(32'h2000, 32'h1000);
                    sf[i] = rf[i] - $urandom_range(16'h100, 0) + 32'h40;
                end
                dly[i] = $urandom_range(150, 0);
                nv[i]  = ($urandom_range(11, 0) == 0);
                if (!nv[i] && rf[i] >= sf[i]) tot += longint'(rf[i]) - longint'(sf[i]);
            end
            case ($urandom_range(3, 0))
                0:       thr = $urandom;
                1:       thr = 32'(tot / N);
                2:       thr = 32'(tot / N) + 32'd1;
                default: thr = '0;
            endcase
            run_scan($sformatf("rand%0d", s), thr, s[0]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
